// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
// Forwarding support in hazard_unit is selected with the HAZARD_FORWARDING_EN macro.
package hazard_pkg;

  localparam int HAZARD_REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'd0,
    FWD_EXECUTE   = 2'd1,
    FWD_MEMORY    = 2'd2,
    FWD_WRITEBACK = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency writes.
// A set and a clear of the same register in one cycle leave it busy: the
// completion belongs to the older operation, the new issue is still in flight.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HAZARD_REG_ADDR_W,
  localparam int NUM_REGS = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] busy_nxt;

  // Next busy vector: apply clear first so a same-register set overrides it.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    if (set_en) busy_nxt[set_idx] = 1'b1;
  end

  // Busy register; reset drops every pending entry.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: compares decode sources against execute, memory and
// writeback destinations, tracks long-latency writes in a scoreboard, and
// counts stalled decode cycles with a saturating counter.
// Build option: define HAZARD_FORWARDING_EN to emit forwarding selects and
// stall only on load-use; otherwise every pipeline match stalls.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W         = HAZARD_REG_ADDR_W,
  parameter bit ZERO_REG_HARDWIRED = 1'b0,
  parameter int STALL_CNT_W        = 16,
  localparam int NUM_REGS = 2 ** REG_ADDR_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_decode_valid,
  input  logic [REG_ADDR_W-1:0]  i_decode_rs1,
  input  logic [REG_ADDR_W-1:0]  i_decode_rs2,
  input  logic                   i_decode_rs1_used,
  input  logic                   i_decode_rs2_used,
  input  logic                   i_issue,
  input  logic [REG_ADDR_W-1:0]  i_issue_ws,
  input  logic                   i_issue_long,
  input  logic [REG_ADDR_W-1:0]  i_execute_ws,
  input  logic                   i_execute_we,
  input  logic                   i_execute_is_load,
  input  logic [REG_ADDR_W-1:0]  i_memory_ws,
  input  logic                   i_memory_we,
  input  logic [REG_ADDR_W-1:0]  i_writeback_ws,
  input  logic                   i_writeback_we,
  input  logic                   i_long_done,
  input  logic [REG_ADDR_W-1:0]  i_long_ws,
  output logic                   o_stall,
  output logic [1:0]             o_fwd_rs1,
  output logic [1:0]             o_fwd_rs2,
  output logic [NUM_REGS-1:0]    o_busy,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] rs);
    return ZERO_REG_HARDWIRED && (rs == '0);
  endfunction

  function automatic logic src_match(input logic                  used,
                                     input logic                  we,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] ws);
    return used && we && (rs == ws) && !is_zero_reg(rs);
  endfunction

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + 1'b1;
  endfunction

  logic     ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
  logic     sb_hit, stage_stall;
  fwd_sel_t fwd_rs1, fwd_rs2;

  assign ex_rs1  = src_match(i_decode_rs1_used, i_execute_we,   i_decode_rs1, i_execute_ws);
  assign ex_rs2  = src_match(i_decode_rs2_used, i_execute_we,   i_decode_rs2, i_execute_ws);
  assign mem_rs1 = src_match(i_decode_rs1_used, i_memory_we,    i_decode_rs1, i_memory_ws);
  assign mem_rs2 = src_match(i_decode_rs2_used, i_memory_we,    i_decode_rs2, i_memory_ws);
  assign wb_rs1  = src_match(i_decode_rs1_used, i_writeback_we, i_decode_rs1, i_writeback_ws);
  assign wb_rs2  = src_match(i_decode_rs2_used, i_writeback_we, i_decode_rs2, i_writeback_ws);

  hazard_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_scoreboard (
    .clk     (i_clk),
    .rst     (i_reset),
    .set_en  (i_issue && i_issue_long),
    .set_idx (i_issue_ws),
    .clr_en  (i_long_done),
    .clr_idx (i_long_ws),
    .busy    (o_busy)
  );

  // Scoreboard reads the registered busy bits only, so a clear shows up a cycle later.
  assign sb_hit = (i_decode_rs1_used && o_busy[i_decode_rs1] && !is_zero_reg(i_decode_rs1)) ||
                  (i_decode_rs2_used && o_busy[i_decode_rs2] && !is_zero_reg(i_decode_rs2));

`ifdef HAZARD_FORWARDING_EN
  // Youngest producer wins: execute, then memory, then writeback.
  always_comb begin
    fwd_rs1 = FWD_REGFILE;
    if (ex_rs1)       fwd_rs1 = FWD_EXECUTE;
    else if (mem_rs1) fwd_rs1 = FWD_MEMORY;
    else if (wb_rs1)  fwd_rs1 = FWD_WRITEBACK;
  end

  // Same priority for the second operand.
  always_comb begin
    fwd_rs2 = FWD_REGFILE;
    if (ex_rs2)       fwd_rs2 = FWD_EXECUTE;
    else if (mem_rs2) fwd_rs2 = FWD_MEMORY;
    else if (wb_rs2)  fwd_rs2 = FWD_WRITEBACK;
  end

  // A load in execute has no data to forward yet.
  assign stage_stall = i_execute_is_load && (ex_rs1 || ex_rs2);
`else
  logic unused_is_load;

  assign fwd_rs1        = FWD_REGFILE;
  assign fwd_rs2        = FWD_REGFILE;
  assign stage_stall    = ex_rs1 || ex_rs2 || mem_rs1 || mem_rs2 || wb_rs1 || wb_rs2;
  assign unused_is_load = i_execute_is_load;
`endif

  assign o_stall   = i_decode_valid && (stage_stall || sb_hit);
  assign o_fwd_rs1 = i_decode_valid ? fwd_rs1 : FWD_REGFILE;
  assign o_fwd_rs2 = i_decode_valid ? fwd_rs2 : FWD_REGFILE;

  // Stalled-cycle counter for performance monitoring, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset)      o_stall_count <= '0;
    else if (o_stall) o_stall_count <= sat_inc(o_stall_count);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit. Expectations follow HAZARD_FORWARDING_EN.
// u_dut: register 0 hardwired, 2-bit counter. u_dut0: register 0 ordinary, 16-bit counter.
module tb_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        decode_valid;
  logic [3:0]  rs1, rs2;
  logic        rs1_used, rs2_used;
  logic        issue;
  logic [3:0]  issue_ws;
  logic        issue_long;
  logic [3:0]  ex_ws;
  logic        ex_we, ex_load;
  logic [3:0]  mem_ws;
  logic        mem_we;
  logic [3:0]  wb_ws;
  logic        wb_we;
  logic        long_done;
  logic [3:0]  long_ws;

  logic        stall, stall0;
  logic [1:0]  fwd1, fwd2, fwd1_0, fwd2_0;
  logic [15:0] busy, busy0;
  logic [1:0]  cnt;
  logic [15:0] cnt0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_unit #(
    .REG_ADDR_W(4), .ZERO_REG_HARDWIRED(1'b1), .STALL_CNT_W(2)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_decode_valid(decode_valid),
    .i_decode_rs1(rs1), .i_decode_rs2(rs2),
    .i_decode_rs1_used(rs1_used), .i_decode_rs2_used(rs2_used),
    .i_issue(issue), .i_issue_ws(issue_ws), .i_issue_long(issue_long),
    .i_execute_ws(ex_ws), .i_execute_we(ex_we), .i_execute_is_load(ex_load),
    .i_memory_ws(mem_ws), .i_memory_we(mem_we),
    .i_writeback_ws(wb_ws), .i_writeback_we(wb_we),
    .i_long_done(long_done), .i_long_ws(long_ws),
    .o_stall(stall), .o_fwd_rs1(fwd1), .o_fwd_rs2(fwd2),
    .o_busy(busy), .o_stall_count(cnt)
  );

  hazard_unit #(
    .REG_ADDR_W(4), .ZERO_REG_HARDWIRED(1'b0), .STALL_CNT_W(16)
  ) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_decode_valid(decode_valid),
    .i_decode_rs1(rs1), .i_decode_rs2(rs2),
    .i_decode_rs1_used(rs1_used), .i_decode_rs2_used(rs2_used),
    .i_issue(issue), .i_issue_ws(issue_ws), .i_issue_long(issue_long),
    .i_execute_ws(ex_ws), .i_execute_we(ex_we), .i_execute_is_load(ex_load),
    .i_memory_ws(mem_ws), .i_memory_we(mem_we),
    .i_writeback_ws(wb_ws), .i_writeback_we(wb_we),
    .i_long_done(long_done), .i_long_ws(long_ws),
    .o_stall(stall0), .o_fwd_rs1(fwd1_0), .o_fwd_rs2(fwd2_0),
    .o_busy(busy0), .o_stall_count(cnt0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    decode_valid = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0;
    issue = 0; issue_ws = 0; issue_long = 0;
    ex_ws = 0; ex_we = 0; ex_load = 0; mem_ws = 0; mem_we = 0;
    wb_ws = 0; wb_we = 0; long_done = 0; long_ws = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected %h", busy, 16'h0); end
    checks++;
    if (cnt !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt); end
    checks++;
    if (stall !== 1'b0 || fwd1 !== 2'd0 || fwd2 !== 2'd0) begin
      errors++; $display("FAIL reset_idle_outputs: got stall=%b fwd1=%0d fwd2=%0d expected 0/0/0", stall, fwd1, fwd2);
    end
  endtask

  task automatic test_stage_match();
    // rs1=3 hit in execute (not load) and memory: execute wins
    idle_inputs();
    decode_valid = 1; rs1 = 3; rs1_used = 1;
    ex_ws = 3; ex_we = 1; mem_ws = 3; mem_we = 1;
    #1;
    checks++;
    if (stall !== (FWD_ON ? 1'b0 : 1'b1) || fwd1 !== (FWD_ON ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL exec_priority: got stall=%b fwd1=%0d expected stall=%b fwd1=%0d",
                         stall, fwd1, !FWD_ON, FWD_ON ? 2'd1 : 2'd0);
    end
    // rs2=4 hit in memory only
    idle_inputs();
    decode_valid = 1; rs2 = 4; rs2_used = 1; mem_ws = 4; mem_we = 1;
    ex_ws = 4; ex_we = 0;
    #1;
    checks++;
    if (stall !== (FWD_ON ? 1'b0 : 1'b1) || fwd2 !== (FWD_ON ? 2'd2 : 2'd0) || fwd1 !== 2'd0) begin
      errors++; $display("FAIL mem_match: got stall=%b fwd1=%0d fwd2=%0d expected stall=%b fwd1=0 fwd2=%0d",
                         stall, fwd1, fwd2, !FWD_ON, FWD_ON ? 2'd2 : 2'd0);
    end
    // rs1=6 hit in writeback, memory holds a different register
    idle_inputs();
    decode_valid = 1; rs1 = 6; rs1_used = 1; wb_ws = 6; wb_we = 1; mem_ws = 7; mem_we = 1;
    #1;
    checks++;
    if (stall !== (FWD_ON ? 1'b0 : 1'b1) || fwd1 !== (FWD_ON ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL wb_match: got stall=%b fwd1=%0d expected stall=%b fwd1=%0d",
                         stall, fwd1, !FWD_ON, FWD_ON ? 2'd3 : 2'd0);
    end
    // rs1=2 in writeback; then the operand unused; then decode invalid
    idle_inputs();
    decode_valid = 1; rs1 = 2; rs1_used = 1; wb_ws = 2; wb_we = 1;
    #1;
    checks++;
    if (stall !== (FWD_ON ? 1'b0 : 1'b1) || fwd1 !== (FWD_ON ? 2'd3 : 2'd0)) begin
      errors++; $display("FAIL wb_rs1_2: got stall=%b fwd1=%0d expected stall=%b fwd1=%0d",
                         stall, fwd1, !FWD_ON, FWD_ON ? 2'd3 : 2'd0);
    end
    rs1_used = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd1 !== 2'd0) begin
      errors++; $display("FAIL unused_src: got stall=%b fwd1=%0d expected 0/0", stall, fwd1);
    end
    rs1_used = 1; decode_valid = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd1 !== 2'd0) begin
      errors++; $display("FAIL invalid_decode: got stall=%b fwd1=%0d expected 0/0", stall, fwd1);
    end
    // no address match with write enables on
    idle_inputs();
    decode_valid = 1; rs1 = 9; rs2 = 10; rs1_used = 1; rs2_used = 1;
    ex_ws = 11; ex_we = 1; ex_load = 1; mem_ws = 12; mem_we = 1; wb_ws = 13; wb_we = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd1 !== 2'd0 || fwd2 !== 2'd0) begin
      errors++; $display("FAIL no_match: got stall=%b fwd1=%0d fwd2=%0d expected 0/0/0", stall, fwd1, fwd2);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    decode_valid = 1; rs2 = 5; rs2_used = 1; ex_ws = 5; ex_we = 1; ex_load = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stall); end
    step();
    ex_we = 0; ex_load = 0; mem_ws = 5; mem_we = 1;
    #1;
    checks++;
    if (stall !== (FWD_ON ? 1'b0 : 1'b1) || fwd2 !== (FWD_ON ? 2'd2 : 2'd0)) begin
      errors++; $display("FAIL load_in_mem: got stall=%b fwd2=%0d expected stall=%b fwd2=%0d",
                         stall, fwd2, !FWD_ON, FWD_ON ? 2'd2 : 2'd0);
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    issue = 1; issue_long = 1; issue_ws = 7;
    step();
    issue = 0; issue_long = 0;
    checks++;
    if (busy !== 16'h0080) begin errors++; $display("FAIL sb_set: got %h expected %h", busy, 16'h0080); end
    decode_valid = 1; rs1 = 7; rs1_used = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall: got %b expected 1", stall); end
    long_done = 1; long_ws = 7;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL sb_no_bypass: got %b expected 1", stall); end
    step();
    long_done = 0;
    #1;
    checks++;
    if (stall !== 1'b0 || busy !== 16'h0) begin
      errors++; $display("FAIL sb_clear: got stall=%b busy=%h expected 0/0000", stall, busy);
    end
    decode_valid = 0; rs1_used = 0;
    issue = 1; issue_long = 1; issue_ws = 7;
    step();
    issue_ws = 7; long_done = 1; long_ws = 7;
    step();
    issue = 0; issue_long = 0; long_done = 0;
    checks++;
    if (busy !== 16'h0080) begin errors++; $display("FAIL sb_set_wins: got %h expected %h", busy, 16'h0080); end
    issue = 1; issue_long = 0; issue_ws = 3;
    long_done = 1; long_ws = 9;
    step();
    issue = 0; long_done = 0;
    checks++;
    if (busy !== 16'h0080) begin errors++; $display("FAIL sb_short_and_stray_done: got %h expected %h", busy, 16'h0080); end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    decode_valid = 1; rs1 = 0; rs1_used = 1; ex_ws = 0; ex_we = 1; ex_load = 1;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd1 !== 2'd0) begin
      errors++; $display("FAIL zero_hardwired: got stall=%b fwd1=%0d expected 0/0", stall, fwd1);
    end
    checks++;
    if (stall0 !== 1'b1 || fwd1_0 !== (FWD_ON ? 2'd1 : 2'd0)) begin
      errors++; $display("FAIL zero_ordinary: got stall=%b fwd1=%0d expected stall=1 fwd1=%0d",
                         stall0, fwd1_0, FWD_ON ? 2'd1 : 2'd0);
    end
    idle_inputs();
  endtask

  task automatic test_counter();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    issue = 1; issue_long = 1; issue_ws = 12;
    step();
    issue = 0; issue_long = 0;
    decode_valid = 1; rs2 = 5; rs2_used = 1; ex_ws = 5; ex_we = 1; ex_load = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (cnt !== exp_cnt[i]) begin
        errors++; $display("FAIL count_cycle%0d: got %0d expected %0d", i + 1, cnt, exp_cnt[i]);
      end
    end
    checks++;
    if (cnt0 !== 16'd5) begin errors++; $display("FAIL count_wide: got %0d expected 5", cnt0); end
    reset = 1;
    step();
    reset = 0;
    checks++;
    if (cnt !== 2'd0 || busy !== 16'h0) begin
      errors++; $display("FAIL reset_mid: got count=%0d busy=%h expected 0/0000", cnt, busy);
    end
    idle_inputs();
    step();
    checks++;
    if (cnt !== 2'd0) begin errors++; $display("FAIL count_hold: got %0d expected 0", cnt); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_stage_match();
    test_load_use();
    test_scoreboard();
    test_zero_reg();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
